// File: rtl/elpis_la_bridge_if.sv
// Signal bundle between the caravel LA pins, the Elpis core memory port and the core I/O handshakes.
interface elpis_la_bridge_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 32
);
  logic [127:0]      la_data_in;
  logic [127:0]      la_oenb;
  logic [127:0]      la_data_out;
  logic              reset_core;
  logic              is_loading_memory_into_core;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] addr_to_core_mem;
  logic [DATA_W-1:0] data_to_core_mem;
  logic [DATA_W-1:0] core_out_data;
  logic              core_out_valid;
  logic              core_out_ready;
  logic              core_rd_req;
  logic [DATA_W-1:0] read_value_to_Elpis;
  logic              read_enable_to_Elpis;
  logic [31:0]       wbs_dat_o;

  // Bridge side
  modport slave (
    input  la_data_in, la_oenb, mem_ready, core_out_data, core_out_valid, core_rd_req,
    output la_data_out, reset_core, is_loading_memory_into_core, mem_we, addr_to_core_mem,
           data_to_core_mem, core_out_ready, read_value_to_Elpis, read_enable_to_Elpis, wbs_dat_o
  );

  // Host / core / memory side
  modport master (
    output la_data_in, la_oenb, mem_ready, core_out_data, core_out_valid, core_rd_req,
    input  la_data_out, reset_core, is_loading_memory_into_core, mem_we, addr_to_core_mem,
           data_to_core_mem, core_out_ready, read_value_to_Elpis, read_enable_to_Elpis, wbs_dat_o
  );
endinterface

// File: rtl/elpis_la_bridge.sv
// LA-to-Elpis bridge: toggle-strobed host commands, buffered memory load, core reset sequencing
// and handshaked core output / read-value paths.
module elpis_la_bridge #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_HOLD = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  elpis_la_bridge_if.slave bus
);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int unsigned ENT_W  = ADDR_W + DATA_W;

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_HALT    = 2'b11;

  typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_DRAIN = 2'd1, ST_RUN = 2'd2} state_t;

  state_t            state_q, state_n;
  logic              cmd_tog_q, rack_tog_q, oack_tog_q;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_n, rd_ptr_q, rd_ptr_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [HOLD_W-1:0] hold_q, hold_n;
  logic              ovf_q, ovf_n, err_q, err_n;
  logic              out_pend_q, out_pend_n, rd_pend_q, rd_pend_n;
  logic [DATA_W-1:0] out_hold_q, out_hold_n, rd_val_q, rd_val_n;
  logic [ENT_W-1:0]  head_q, head_n, push_ent;
  logic              mem_we_q, reset_core_q, loading_q, out_ready_q, rd_en_q, rd_en_n;
  logic [127:0]      la_out_q, la_out_n;
  logic [31:0]       wbs_q;
  logic              fire, is_nop, is_wr, is_rel, is_halt, clr, rack, oack;
  logic              push, do_push, pop, full, capture, halt_clr, ovf_set, err_set;
  logic              unused_la;

  assign unused_la = ^{bus.la_data_in, bus.la_oenb};

  // Strobe and ack edge detection against the registered toggle references
  always_comb begin
    fire     = (bus.la_data_in[96] != cmd_tog_q) && !bus.la_oenb[96];
    is_nop   = fire && (bus.la_data_in[98:97] == OP_NOP);
    is_wr    = fire && (bus.la_data_in[98:97] == OP_WRITE);
    is_rel   = fire && (bus.la_data_in[98:97] == OP_RELEASE);
    is_halt  = fire && (bus.la_data_in[98:97] == OP_HALT);
    clr      = is_nop && bus.la_data_in[32];
    rack     = bus.la_data_in[99] != rack_tog_q;
    oack     = bus.la_data_in[101] != oack_tog_q;
    push_ent = {bus.la_data_in[ADDR_W-1:0], bus.la_data_in[32 +: DATA_W]};
  end

  always_comb begin
    state_n  = state_q;
    hold_n   = hold_q;
    push     = 1'b0;
    halt_clr = 1'b0;
    err_set  = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        push = is_wr;
        if (is_rel) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        push = is_wr;
        if (is_halt) begin
          state_n = ST_LOAD;
          hold_n  = '0;
        end else if ((cnt_q != '0) || push) begin
          hold_n = '0;
        end else if (hold_q == HOLD_W'(RESET_HOLD - 1)) begin
          state_n = ST_RUN;
          hold_n  = '0;
        end else begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        err_set = is_wr || is_rel;
        if (is_halt) begin
          state_n  = ST_LOAD;
          halt_clr = 1'b1;
        end
      end
      default: state_n = ST_LOAD;
    endcase

    // Write FIFO; a pop frees the slot a same-cycle push needs when full
    full     = cnt_q == CNT_W'(FIFO_DEPTH);
    pop      = mem_we_q && bus.mem_ready;
    do_push  = push && (!full || pop);
    ovf_set  = push && full && !pop;
    cnt_n    = cnt_q + CNT_W'(do_push) - CNT_W'(pop);
    rd_ptr_n = rd_ptr_q + PTR_W'(pop);
    wr_ptr_n = wr_ptr_q + PTR_W'(do_push);
    head_n   = (do_push && (rd_ptr_n == wr_ptr_q)) ? push_ent : fifo_mem[rd_ptr_n];

    ovf_n = ovf_set || (ovf_q && !clr);
    err_n = err_set || (err_q && !clr);

    // Output path: ready is low while pending, so capture and ack never collide
    capture    = (state_q == ST_RUN) && bus.core_out_valid && out_ready_q;
    out_hold_n = capture ? bus.core_out_data : out_hold_q;
    out_pend_n = out_pend_q;
    if (halt_clr)     out_pend_n = 1'b0;
    else if (capture) out_pend_n = 1'b1;
    else if (oack)    out_pend_n = 1'b0;

    rd_en_n   = 1'b0;
    rd_val_n  = rd_val_q;
    rd_pend_n = rd_pend_q;
    if (halt_clr) begin
      rd_pend_n = 1'b0;
    end else if (rack && rd_pend_q) begin
      rd_pend_n = 1'b0;
      rd_en_n   = 1'b1;
      rd_val_n  = bus.la_data_in[64 +: DATA_W];
    end else if ((state_q == ST_RUN) && bus.core_rd_req) begin
      rd_pend_n = 1'b1;
    end

    la_out_n             = '0;
    la_out_n[DATA_W-1:0] = out_hold_n;
    la_out_n[100]        = out_pend_n;
    la_out_n[102]        = rd_pend_n;
    la_out_n[104:103]    = state_n;
    la_out_n[105]        = ovf_n;
    la_out_n[106]        = err_n;
    la_out_n[112:107]    = 6'(cnt_n);
    la_out_n[113]        = cnt_n == CNT_W'(FIFO_DEPTH);
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) fifo_mem[wr_ptr_q] <= push_ent;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= ST_LOAD;
      cmd_tog_q    <= 1'b0;
      rack_tog_q   <= 1'b0;
      oack_tog_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      out_pend_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      out_hold_q   <= '0;
      rd_val_q     <= '0;
      head_q       <= '0;
      mem_we_q     <= 1'b0;
      reset_core_q <= 1'b1;
      loading_q    <= 1'b1;
      out_ready_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      la_out_q     <= '0;
      wbs_q        <= '0;
    end else begin
      state_q      <= state_n;
      cmd_tog_q    <= bus.la_data_in[96];
      rack_tog_q   <= bus.la_data_in[99];
      oack_tog_q   <= bus.la_data_in[101];
      wr_ptr_q     <= wr_ptr_n;
      rd_ptr_q     <= rd_ptr_n;
      cnt_q        <= cnt_n;
      hold_q       <= hold_n;
      ovf_q        <= ovf_n;
      err_q        <= err_n;
      out_pend_q   <= out_pend_n;
      rd_pend_q    <= rd_pend_n;
      out_hold_q   <= out_hold_n;
      rd_val_q     <= rd_val_n;
      head_q       <= head_n;
      mem_we_q     <= cnt_n != '0;
      reset_core_q <= state_n != ST_RUN;
      loading_q    <= state_n != ST_RUN;
      out_ready_q  <= (state_n == ST_RUN) && !out_pend_n;
      rd_en_q      <= rd_en_n;
      la_out_q     <= la_out_n;
      wbs_q        <= 32'(out_hold_n);
    end
  end

  assign bus.la_data_out                 = la_out_q;
  assign bus.reset_core                  = reset_core_q;
  assign bus.is_loading_memory_into_core = loading_q;
  assign bus.mem_we                      = mem_we_q;
  assign bus.addr_to_core_mem            = head_q[ENT_W-1:DATA_W];
  assign bus.data_to_core_mem            = head_q[DATA_W-1:0];
  assign bus.core_out_ready              = out_ready_q;
  assign bus.read_value_to_Elpis         = rd_val_q;
  assign bus.read_enable_to_Elpis        = rd_en_q;
  assign bus.wbs_dat_o                   = wbs_q;
endmodule

// File: doc/elpis_la_bridge.md
Name: elpis_la_bridge

Overview:
- Parametrised, sequential successor to the Elpis LA-to-core glue.
- The management SoC drives commands over the 128-bit logic-analyser bus using toggle strobes.
- Memory writes pass through a FIFO to the core memory port, and a state machine sequences core reset for load and run.
- Core output and core read requests use explicit handshakes, so no LA-side data is lost.
- Sits between the caravel LA pins and the Elpis core/memory wrapper.

Parameters:
- ADDR_W, 20, core memory address width (1..32), taken from la_data_in[ADDR_W-1:0].
- DATA_W, 32, data width (1..32), taken from la_data_in[32+DATA_W-1:32], read value from la_data_in[64+DATA_W-1:64].
- FIFO_DEPTH, 4, write FIFO entries; power of two, 2..32.
- RESET_HOLD, 8, cycles reset_core stays high after a release before RUN (>=1).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_n  in  1  asynchronous active-low reset.
- la_data_in  in  128  host data/commands.
- la_oenb  in  128  LA output-enable-bar; commands honoured only while la_oenb[96]==0.
- la_data_out  out  128  status/data to host.
- reset_core  out  1  core reset, active high.
- is_loading_memory_into_core  out  1  high in LOAD/DRAIN.
- mem_we  out  1  write request to core memory.
- mem_ready  in  1  memory accepts write when mem_we&&mem_ready.
- addr_to_core_mem  out  ADDR_W  write address.
- data_to_core_mem  out  DATA_W  write data.
- core_out_data  in  DATA_W  core output value.
- core_out_valid  in  1  core output offered.
- core_out_ready  out  1  bridge accepts output.
- core_rd_req  in  1  single-cycle pulse, core requests input value.
- read_value_to_Elpis  out  DATA_W  value returned to core.
- read_enable_to_Elpis  out  1  one-cycle valid for read_value_to_Elpis.
- wbs_dat_o  out  32  mirror of the output holding register, zero-extended.

Behaviour:
- Command strobe: bit 96 is the toggle.
  - Register it; a command fires one cycle after any change while la_oenb[96]==0.
  - If la_oenb[96]==1, the toggle reference is still tracked but no command fires.
  - Opcode is la_data_in[98:97]: 00 NOP, 01 WRITE, 10 RELEASE, 11 HALT.
- Ack toggles: bit 99 is the read-ack toggle; bit 101 is the out-ack toggle. Each has its own registered edge detect.
- Reset state: LOAD, FIFO empty, all sticky flags 0, reset_core=1, mem_we=0, read_enable_to_Elpis=0, core_out_ready=0, la_data_out=0, wbs_dat_o=0.
- FSM:
  - LOAD (2'd0): reset_core=1, loading=1. WRITE pushes {addr,data}; if the FIFO is full, drop the entry and set ovf sticky. RELEASE -> DRAIN.
  - DRAIN (2'd1): loading=1, reset_core=1. WRITE is still accepted. When the FIFO is empty and no write is in flight, hold reset_core for RESET_HOLD cycles, then -> RUN. HALT -> LOAD.
  - RUN (2'd2): reset_core=0, loading=0, core_out_ready active. WRITE or RELEASE sets err sticky and is otherwise ignored. HALT -> LOAD next cycle, clears out_pending and read_pending.
- FIFO drain:
  - mem_we is high whenever the FIFO is non-empty.
  - Head entry drives addr_to_core_mem and data_to_core_mem, which stay stable until mem_ready.
  - Pop on mem_we&&mem_ready.
  - Simultaneous push and pop when full succeeds: no drop.
- NOP with la_data_in[32]==1 clears the ovf and err stickies. If a sticky set and a clear occur in the same cycle, set wins.
- Output path (RUN only):
  - core_out_ready = ~out_pending.
  - On valid&&ready: capture into the holding register, out_pending=1.
  - An out-ack edge clears out_pending.
  - Capture and ack in the same cycle: ack clears the old pending state, and the new capture is blocked that cycle because ready was already 0.
- Read path:
  - core_rd_req in RUN sets read_pending; a request while already pending is ignored.
  - A read-ack edge while pending gives read_enable_to_Elpis=1 for exactly one cycle with read_value_to_Elpis = la_data_in[64+:DATA_W], then clears pending.
  - A read-ack edge while not pending is ignored.
- la_data_out map (all bits registered, unused bits 0):
  - [DATA_W-1:0] holding register.
  - [100] out_pending.
  - [102] read_pending.
  - [104:103] state.
  - [105] ovf.
  - [106] err.
  - [112:107] FIFO count.
  - [113] FIFO full.
- Asynchronous reset mid-write: mem_we drops immediately and the FIFO is emptied.

Test Plan:
- After reset, toggle bit 96 with op=01, addr=0x00010, data=0xDEADBEEF, mem_ready=1 -> mem_we high one cycle later with those values, FIFO count returns to 0, state=LOAD.
- With mem_ready=0, issue 5 writes (FIFO_DEPTH=4) -> count=4, full=1, ovf=1. Raise mem_ready -> 4 writes drain in order, 5th never appears. NOP with bit32=1 -> ovf=0.
- RELEASE with 2 entries queued -> DRAIN until empty, reset_core high exactly 8 more cycles, then state=2, reset_core=0.
- In RUN, core_out_valid with data 0x12345678 -> la_data_out[31:0]=0x12345678, [100]=1, ready=0. A second valid stalls until bit 101 toggles.
- In RUN, core_rd_req pulse -> [102]=1. Host sets [95:64]=0xCAFE0001 and toggles bit 99 -> one-cycle read_enable_to_Elpis with 0xCAFE0001, [102]=0.
- WRITE in RUN -> err=1, no mem_we. HALT -> LOAD, reset_core=1. Toggling bit 96 with la_oenb[96]=1 -> no command.
